// File: rtl/motor_puertas.sv
// Door motor controller: tracks door position and open dwell time, drives the
// actuator and flags a timeout once the door has been open and idle too long.
module motor_puertas #(
    parameter int T_MOV    = 8,
    parameter int T_ESPERA = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] salida_puertas,
    input  logic       sensor,
    output logic [1:0] puertas,
    output logic       timeout,
    output logic [1:0] motor
);

    typedef enum logic [1:0] {
        CERRADA  = 2'b00,
        ABIERTA  = 2'b01,
        CERRANDO = 2'b10,
        ABRIENDO = 2'b11
    } estado_t;

    localparam logic [7:0] POS_OPEN    = 8'(T_MOV);
    localparam logic [7:0] POS_LAST    = 8'(T_MOV - 1);
    localparam logic [7:0] ESPERA_MAX  = 8'(T_ESPERA);

    localparam logic [1:0] CMD_OPEN    = 2'b01;
    localparam logic [1:0] CMD_CLOSE   = 2'b10;

    localparam logic [1:0] MOTOR_OPEN  = 2'b01;
    localparam logic [1:0] MOTOR_CLOSE = 2'b10;
    localparam logic [1:0] MOTOR_OFF   = 2'b00;

    estado_t    state_q, state_d;
    logic [7:0] pos_q, pos_d;
    logic [7:0] espera_q, espera_d;
    logic       timeout_q, timeout_d;
    logic [1:0] motor_q, motor_d;

    logic       cmd_open_s;
    logic       cmd_close_s;

    // 11 is not a valid command and decodes to neither open nor close.
    assign cmd_open_s  = (salida_puertas == CMD_OPEN);
    assign cmd_close_s = (salida_puertas == CMD_CLOSE);

    // Next-state, position and dwell computation.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        espera_d = espera_q;
        case (state_q)
            CERRADA: begin
                espera_d = 8'd0;
                pos_d    = 8'd0;
                if (cmd_open_s) begin
                    state_d = ABRIENDO;
                end else begin
                    state_d = CERRADA;
                end
            end
            ABRIENDO: begin
                espera_d = 8'd0;
                if (cmd_close_s && !sensor) begin
                    state_d = CERRANDO;
                end else if (pos_q >= POS_LAST) begin
                    // Last step of travel; also covers a reversal that
                    // happened right at the open end.
                    pos_d   = POS_OPEN;
                    state_d = ABIERTA;
                end else begin
                    pos_d = pos_q + 8'd1;
                end
            end
            ABIERTA: begin
                if (sensor) begin
                    espera_d = 8'd0;
                end else if (cmd_open_s) begin
                    espera_d = 8'd0;
                end else if (cmd_close_s) begin
                    state_d  = CERRANDO;
                    pos_d    = POS_OPEN;
                    espera_d = 8'd0;
                end else if (espera_q < ESPERA_MAX) begin
                    espera_d = espera_q + 8'd1;
                end else begin
                    espera_d = ESPERA_MAX;
                end
            end
            CERRANDO: begin
                espera_d = 8'd0;
                if (sensor || cmd_open_s) begin
                    state_d = ABRIENDO;
                end else if (pos_q <= 8'd1) begin
                    // Last step of travel; also covers a reversal that
                    // happened right at the closed end.
                    pos_d   = 8'd0;
                    state_d = CERRADA;
                end else begin
                    pos_d = pos_q - 8'd1;
                end
            end
            default: begin
                state_d  = CERRADA;
                pos_d    = 8'd0;
                espera_d = 8'd0;
            end
        endcase
    end

    // Registered outputs derived from the next state so they line up with it.
    always_comb begin
        timeout_d = (state_d == ABIERTA) && (espera_d == ESPERA_MAX);
        case (state_d)
            ABRIENDO: motor_d = MOTOR_OPEN;
            CERRANDO: motor_d = MOTOR_CLOSE;
            CERRADA:  motor_d = MOTOR_OFF;
            ABIERTA:  motor_d = MOTOR_OFF;
            default:  motor_d = MOTOR_OFF;
        endcase
    end

    // State, counters and outputs; reset drops everything to closed/idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CERRADA;
            pos_q     <= 8'd0;
            espera_q  <= 8'd0;
            timeout_q <= 1'b0;
            motor_q   <= MOTOR_OFF;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            espera_q  <= espera_d;
            timeout_q <= timeout_d;
            motor_q   <= motor_d;
        end
    end

    assign puertas = state_q;
    assign timeout = timeout_q;
    assign motor   = motor_q;

endmodule

// File: tb/tb_motor_puertas.sv
// Directed bench for motor_puertas (T_MOV=8, T_ESPERA=20). Each step pushes
// the expected {puertas, motor, timeout} into a queue and pops it after the edge.
module tb_motor_puertas;

    logic       clk;
    logic       reset;
    logic [1:0] salida_puertas;
    logic       sensor;
    logic [1:0] puertas;
    logic       timeout;
    logic [1:0] motor;

    int vectors;
    int miscompares;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    motor_puertas #(.T_MOV(8), .T_ESPERA(20)) dut (
        .clk            (clk),
        .reset          (reset),
        .salida_puertas (salida_puertas),
        .sensor         (sensor),
        .puertas        (puertas),
        .timeout        (timeout),
        .motor          (motor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input string tag, input logic [1:0] ep,
                              input logic [1:0] em, input logic et);
        exp_q.push_back({ep, em, et});
        tag_q.push_back(tag);
    endtask

    task automatic check_out();
        logic [4:0] exp_v;
        logic [4:0] obs_v;
        string      tag;
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        obs_v = {puertas, motor, timeout};
        vectors++;
        assert (obs_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed puertas=%b motor=%b timeout=%b expected puertas=%b motor=%b timeout=%b",
                   tag, obs_v[4:3], obs_v[2:1], obs_v[0], exp_v[4:3], exp_v[2:1], exp_v[0]);
        end
    endtask

    // One clock: drive inputs, queue expectation, sample #1 after the edge.
    task automatic step(input string tag, input logic [1:0] cmd, input logic sen,
                        input logic [1:0] ep, input logic [1:0] em, input logic et);
        salida_puertas = cmd;
        sensor         = sen;
        expect_out(tag, ep, em, et);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic steps(input string tag, input int n, input logic [1:0] cmd, input logic sen,
                         input logic [1:0] ep, input logic [1:0] em, input logic et);
        for (int i = 0; i < n; i++) begin
            step(tag, cmd, sen, ep, em, et);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        salida_puertas = 2'b00;
        sensor         = 1'b0;
        reset          = 1'b1;
        #1;
        expect_out("reset_state", 2'b00, 2'b00, 1'b0);
        check_out();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Full opening: 1 command edge + 7 travelling edges, open on the 8th.
        step ("open_cmd",      2'b01, 1'b0, 2'b11, 2'b01, 1'b0);
        steps("opening", 7,    2'b00, 1'b0, 2'b11, 2'b01, 1'b0);
        step ("opened",        2'b00, 1'b0, 2'b01, 2'b00, 1'b0);

        // Dwell: timeout exactly 20 edges after entering ABIERTA, then holds.
        steps("dwell", 19,     2'b00, 1'b0, 2'b01, 2'b00, 1'b0);
        step ("timeout_on",    2'b00, 1'b0, 2'b01, 2'b00, 1'b1);
        step ("timeout_sat",   2'b00, 1'b0, 2'b01, 2'b00, 1'b1);

        // Close: timeout drops with the state change; closed 8 edges later.
        step ("close_cmd",     2'b10, 1'b0, 2'b10, 2'b10, 1'b0);
        steps("closing", 7,    2'b00, 1'b0, 2'b10, 2'b10, 1'b0);
        step ("closed",        2'b00, 1'b0, 2'b00, 2'b00, 1'b0);

        // Reopen, then obstruction during closing at pos=3.
        step ("open_cmd2",     2'b01, 1'b0, 2'b11, 2'b01, 1'b0);
        steps("opening2", 7,   2'b00, 1'b0, 2'b11, 2'b01, 1'b0);
        step ("opened2",       2'b00, 1'b0, 2'b01, 2'b00, 1'b0);
        step ("close_cmd2",    2'b10, 1'b0, 2'b10, 2'b10, 1'b0);
        steps("closing2", 5,   2'b00, 1'b0, 2'b10, 2'b10, 1'b0);
        step ("sensor_rev",    2'b00, 1'b1, 2'b11, 2'b01, 1'b0);
        steps("reopening", 4,  2'b00, 1'b0, 2'b11, 2'b01, 1'b0);
        step ("reopened",      2'b00, 1'b0, 2'b01, 2'b00, 1'b0);

        // Sensor pulse at dwell 10, then close held while obstructed.
        steps("dwell3", 9,     2'b00, 1'b0, 2'b01, 2'b00, 1'b0);
        step ("sensor_pulse",  2'b00, 1'b1, 2'b01, 2'b00, 1'b0);
        steps("close_blocked", 3, 2'b10, 1'b1, 2'b01, 2'b00, 1'b0);
        steps("dwell4", 19,    2'b00, 1'b0, 2'b01, 2'b00, 1'b0);
        step ("timeout_on2",   2'b00, 1'b0, 2'b01, 2'b00, 1'b1);

        // Reopen request while closing at pos=6 takes two edges to reach open.
        step ("close_cmd3",    2'b10, 1'b0, 2'b10, 2'b10, 1'b0);
        steps("closing3", 2,   2'b00, 1'b0, 2'b10, 2'b10, 1'b0);
        step ("cmd_rev",       2'b01, 1'b0, 2'b11, 2'b01, 1'b0);
        step ("reopening3",    2'b00, 1'b0, 2'b11, 2'b01, 1'b0);
        step ("reopened3",     2'b00, 1'b0, 2'b01, 2'b00, 1'b0);

        // Full close, then open to pos=4 and hit async reset between edges.
        step ("close_cmd4",    2'b10, 1'b0, 2'b10, 2'b10, 1'b0);
        steps("closing4", 7,   2'b00, 1'b0, 2'b10, 2'b10, 1'b0);
        step ("closed4",       2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        step ("open_cmd5",     2'b01, 1'b0, 2'b11, 2'b01, 1'b0);
        steps("opening5", 4,   2'b00, 1'b0, 2'b11, 2'b01, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        expect_out("async_reset", 2'b00, 2'b00, 1'b0);
        check_out();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Closed door ignores 11, and close with obstruction, and idle.
        steps("cmd_11", 2,     2'b11, 1'b0, 2'b00, 2'b00, 1'b0);
        step ("close_closed",  2'b10, 1'b1, 2'b00, 2'b00, 1'b0);
        step ("idle_closed",   2'b00, 1'b0, 2'b00, 2'b00, 1'b0);
        step ("open_after_rst", 2'b01, 1'b1, 2'b11, 2'b01, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/motor_puertas.md
MOTOR_PUERTAS -- requirements
Module: motor_puertas

Interface
REQ-001 Parameter T_MOV, default 8: cycles for a full door travel between closed and open, legal range 2..255.
REQ-002 Parameter T_ESPERA, default 20: cycles the door stays open before timeout asserts, legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset; asynchronous and active-high.
REQ-005 salida_puertas  input  2  door command from the door controller: 01 open, 10 close, 00 none, 11 treated as 00.
REQ-006 sensor  input  1  obstruction between the doors: 1 sensed, 0 clear.
REQ-007 puertas  output  2  door state: 00 fully closed, 01 fully open, 10 closing, 11 opening.
REQ-008 timeout  output  1  door has been open and idle for T_ESPERA cycles.
REQ-009 motor  output  2  actuator drive: 01 open, 10 close, 00 off.

Function
REQ-010 The block SHALL hold a 4-state FSM (CERRADA=00, ABIERTA=01, CERRANDO=10, ABRIENDO=11), and puertas SHALL equal the state register directly.
REQ-011 The block SHALL hold an 8-bit position counter pos (0 = closed, T_MOV = open) and an 8-bit dwell counter espera.
REQ-012 CERRADA: salida_puertas=01 SHALL move to ABRIENDO with pos held at 0; any other command SHALL leave state unchanged.
REQ-013 ABRIENDO: salida_puertas=10 with sensor=0 SHALL move to CERRANDO with pos unchanged; otherwise pos SHALL increment each cycle.
REQ-014 ABRIENDO: the edge where pos goes from T_MOV-1 to T_MOV SHALL also move to ABIERTA and clear espera, so a full opening takes T_MOV cycles.
REQ-015 ABIERTA, with priority: sensor=1 clears espera; else salida_puertas=01 clears espera; else salida_puertas=10 moves to CERRANDO with pos=T_MOV; else espera increments, saturating at T_ESPERA.
REQ-016 CERRANDO: sensor=1 or salida_puertas=01 SHALL move to ABRIENDO with pos unchanged; sensor takes priority over any command.
REQ-017 CERRANDO: otherwise pos SHALL decrement, and the edge where pos goes from 1 to 0 SHALL also move to CERRADA.
REQ-018 A reversal at position p SHALL reach the opposite end after T_MOV-p cycles (reopening) or p cycles (closing).
REQ-019 timeout SHALL be 1 exactly when state=ABIERTA and espera=T_ESPERA.
REQ-020 timeout SHALL deassert on the same edge the state leaves ABIERTA, or on the edge espera is cleared.
REQ-021 motor SHALL be 01 in ABRIENDO, 10 in CERRANDO, and 00 in CERRADA and ABIERTA.
REQ-022 Commands sampled at edge k SHALL be reflected on puertas and motor immediately after edge k (one-cycle latency).
REQ-023 pos SHALL never leave 0..T_MOV, and espera SHALL never exceed T_ESPERA.
REQ-024 No command SHALL be accepted from a fully open or fully closed state while sensor=1 blocks it (close requests); open requests SHALL always be accepted.

Reset
REQ-025 reset=1 SHALL immediately, without a clock edge, force state CERRADA, pos=0, espera=0, puertas=00, timeout=0 and motor=00.
REQ-026 Reset asserted mid-travel SHALL discard the motion in progress; after reset release the block SHALL wait in CERRADA for a new command.

Verification (T_MOV=8, T_ESPERA=20)
REQ-027 Reset, then salida_puertas=01 for one cycle -> puertas=11 and motor=01 after that edge; puertas=01 and motor=00 exactly 8 cycles later.
REQ-028 Door open, salida_puertas=00, sensor=0 -> timeout=1 exactly 20 cycles after entering ABIERTA; then salida_puertas=10 -> puertas=10 and timeout=0 next edge; puertas=00 8 cycles later.
REQ-029 Closing from open, sensor=1 when pos=3 -> puertas=11 next edge; puertas=01 5 cycles later; timeout stays 0.
REQ-030 Open with sensor pulsed at dwell cycle 10 and salida_puertas=10 held with sensor=1 -> state stays 01; timeout asserts 20 cycles after the last sensor cycle.
REQ-031 Async reset pulse mid-opening (pos=4), no clock edge -> puertas=00, motor=00, timeout=0 immediately; salida_puertas=11 in CERRADA afterwards -> no state change.
